regfile_seq_ctrl: RTL and testbench
===================================

Name: regfile_seq_ctrl

Overview:
- Multi-cycle sequencer that owns every port of the 4-entry x 8-bit register file.
- Accepts one 8-bit instruction per valid/ready handshake and decodes it.
- Drives both read addresses, computes the result internally, then issues exactly one single-cycle write-back with wren.
- Sits between the instruction source (fetch/testbench) and the register file; the register file has no other master.

Parameters:
- DATA_W, 8, datapath width of register contents, wdata and imm. Must match the register file width.
- ADDR_W, 2, register address width. Fixed at 2 by the instruction encoding.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- instr  in  8  instruction word: [7:6] opcode, [5:4] rd, [3:2] rs, [1:0] rt.
- imm  in  DATA_W  immediate for LDI; sampled with instr at accept.
- instr_valid  in  1  instr/imm valid.
- instr_ready  out  1  controller can accept an instruction.
- raddr0  out  ADDR_W  to register file read port 0 (rs).
- raddr1  out  ADDR_W  to register file read port 1 (rt).
- rdata0  in  DATA_W  from register file; combinational read of raddr0.
- rdata1  in  DATA_W  from register file; combinational read of raddr1.
- waddr  out  ADDR_W  to register file write address.
- wdata  out  DATA_W  to register file write data.
- wren  out  1  to register file write enable.
- busy  out  1  instruction in flight.
- done  out  1  one-cycle pulse in the write-back cycle.
- carry  out  1  carry/borrow flag of the last ADD/SUB.
- zero  out  1  set when the last written value is 0.

Behaviour:
- Opcodes:
  - 00 ADD: rd = rs + rt; carry = bit DATA_W of the (DATA_W+1)-bit sum.
  - 01 SUB: rd = rs - rt modulo 2^DATA_W; carry = borrow (1 when rs < rt unsigned).
  - 10 MOV: rd = rs; carry unchanged.
  - 11 LDI: rd = imm; rs/rt fields ignored; carry unchanged.
- FSM states: IDLE, READ, WRITE. Encoding is free.
- IDLE:
  - instr_ready=1, busy=0.
  - On instr_valid && instr_ready at edge N: latch instr and imm, go to READ.
- READ (cycle N+1):
  - raddr0=rs and raddr1=rt, from the latched instr.
  - On edge N+2: result and next-flag values registered from rdata0/rdata1 (or imm); go to WRITE.
- WRITE (cycle N+2):
  - wren=1, waddr=rd, wdata=result, done=1.
  - Flags update on edge N+3.
  - Edge N+3: return to IDLE.
- Latency and throughput: accept to wren = 2 cycles; one instruction every 3 cycles; instr_ready high only in IDLE.
- wren rules:
  - High for exactly one cycle per instruction; low in all other states.
  - waddr and wdata stable for the whole wren cycle and held at their last value otherwise, so the register file never sees a glitching write.
- Outside READ, raddr0/raddr1 hold their last value. Their value is don't-care outside READ.
- No hazard logic is needed: the write completes before the next READ.
  - rd equal to rs/rt in the same instruction reads the old value.
  - Back-to-back writes to the same rd: the later one wins.
- instr_valid while not ready: ignored; the instruction is not latched. The source must hold instr/imm/valid until instr_ready.
- zero: updated on every write-back, including MOV and LDI; 1 when wdata == 0.
- Reset values (sync, active-high, takes priority over everything):
  - State IDLE; instr_ready=1 after reset deasserts; busy=0, wren=0, done=0, carry=0, zero=0.
  - raddr0=raddr1=waddr=0, wdata=0.
- Reset mid-operation, including during WRITE: the FSM is in IDLE on the next cycle with wren=0. The aborted instruction produces no further write and no done.
- Register file contents are not cleared by this block.

Test Plan:
- All registers 0; LDI r1,imm=0xAA, then LDI r2,imm=0x55 -> each shows wren=1 exactly 2 cycles after accept with waddr=1/wdata=0xAA, then waddr=2/wdata=0x55; zero=0.
- ADD r3=r1+r2 (instr 0x36) -> wdata=0xFF, waddr=3, carry=0, zero=0. Then ADD r0=r3+r1 (0x0D) -> wdata=0xA9, carry=1.
- SUB r0=r2-r1 (0x49) -> wdata=0xAB, carry=1. Then SUB r0=r1-r1 (0x45) -> wdata=0x00, zero=1, carry=0.
- Hold instr_valid high continuously with 3 MOV instructions -> instr_ready pattern 1,0,0 repeating; done pulses every 3rd cycle; exactly one wren per instruction.
- Assert reset in the READ cycle of an ADD -> no wren ever asserted for that ADD; next cycle idle with instr_ready=1, carry=0, zero=0.
- instr_valid asserted during READ/WRITE with a different instr -> not accepted until IDLE; the value held at IDLE is the one executed.

Source files
------------

// File: rtl/regfile_seq_ctrl.sv
// Three-state sequencer that owns the 4 x DATA_W register file: accept, read, write back.
// One instruction per three cycles; all outputs are registered.
module regfile_seq_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        instr,
    input  logic [DATA_W-1:0] imm,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [ADDR_W-1:0] raddr0,
    output logic [ADDR_W-1:0] raddr1,
    input  logic [DATA_W-1:0] rdata0,
    input  logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic              wren,
    output logic              busy,
    output logic              done,
    output logic              carry,
    output logic              zero
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MOV = 2'b10;
    localparam logic [1:0] OP_LDI = 2'b11;

    state_t              state_q;
    logic [1:0]          op_q;
    logic [ADDR_W-1:0]   rd_q;
    logic [DATA_W-1:0]   imm_q;
    logic [ADDR_W-1:0]   raddr0_q;
    logic [ADDR_W-1:0]   raddr1_q;
    logic [ADDR_W-1:0]   waddr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                wren_q;
    logic                done_q;
    logic                ready_q;
    logic                busy_q;
    logic                carry_q;
    logic                zero_q;
    // Flags computed in READ are held here and published as write-back ends.
    logic                carry_nxt_q;
    logic                zero_nxt_q;

    logic [DATA_W:0]     sum_s;
    logic [DATA_W:0]     diff_s;
    logic [DATA_W-1:0]   result_d;
    logic                carry_d;
    logic                zero_d;

    // ALU: result and carry/borrow from the combinational register-file read data.
    always_comb begin
        sum_s    = {1'b0, rdata0} + {1'b0, rdata1};
        diff_s   = {1'b0, rdata0} - {1'b0, rdata1};
        result_d = {DATA_W{1'b0}};
        carry_d  = carry_q;
        case (op_q)
            OP_ADD: begin
                result_d = sum_s[DATA_W-1:0];
                carry_d  = sum_s[DATA_W];
            end
            OP_SUB: begin
                result_d = diff_s[DATA_W-1:0];
                carry_d  = diff_s[DATA_W];
            end
            OP_MOV: begin
                result_d = rdata0;
                carry_d  = carry_q;
            end
            OP_LDI: begin
                result_d = imm_q;
                carry_d  = carry_q;
            end
            default: begin
                result_d = {DATA_W{1'b0}};
                carry_d  = carry_q;
            end
        endcase
        zero_d = (result_d == {DATA_W{1'b0}});
    end

    // Sequencer FSM with registered outputs; reset aborts any instruction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= 2'b00;
            rd_q        <= {ADDR_W{1'b0}};
            imm_q       <= {DATA_W{1'b0}};
            raddr0_q    <= {ADDR_W{1'b0}};
            raddr1_q    <= {ADDR_W{1'b0}};
            waddr_q     <= {ADDR_W{1'b0}};
            wdata_q     <= {DATA_W{1'b0}};
            wren_q      <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            carry_nxt_q <= 1'b0;
            zero_nxt_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    wren_q <= 1'b0;
                    done_q <= 1'b0;
                    if (instr_valid && ready_q) begin
                        op_q     <= instr[7:6];
                        rd_q     <= instr[5:4];
                        raddr0_q <= instr[3:2];
                        raddr1_q <= instr[1:0];
                        imm_q    <= imm;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= S_READ;
                    end else begin
                        ready_q  <= 1'b1;
                        busy_q   <= 1'b0;
                    end
                end
                S_READ: begin
                    waddr_q     <= rd_q;
                    wdata_q     <= result_d;
                    wren_q      <= 1'b1;
                    done_q      <= 1'b1;
                    carry_nxt_q <= carry_d;
                    zero_nxt_q  <= zero_d;
                    state_q     <= S_WRITE;
                end
                S_WRITE: begin
                    wren_q  <= 1'b0;
                    done_q  <= 1'b0;
                    carry_q <= carry_nxt_q;
                    zero_q  <= zero_nxt_q;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    wren_q  <= 1'b0;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign instr_ready = ready_q;
    assign raddr0      = raddr0_q;
    assign raddr1      = raddr1_q;
    assign waddr       = waddr_q;
    assign wdata       = wdata_q;
    assign wren        = wren_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign carry       = carry_q;
    assign zero        = zero_q;

endmodule

// File: tb/tb_regfile_seq_ctrl.sv
// Self-checking bench: behavioural register file plus an arithmetic reference model,
// directed scenarios followed by randomized instructions.
module tb_regfile_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] instr;
    logic [7:0] imm;
    logic       instr_valid;
    logic       instr_ready;
    logic [1:0] raddr0, raddr1, waddr;
    logic [7:0] rdata0, rdata1, wdata;
    logic       wren, busy, done, carry, zero;

    logic [7:0] rf [4];
    logic       rf_clear;
    int         wren_cnt = 0;

    int         m_rf [4];
    int         m_carry, m_zero;
    int         exp_writes;
    int         n_checks, n_pass;

    always #5 clk = ~clk;

    regfile_seq_ctrl #(.DATA_W(8), .ADDR_W(2)) dut (
        .clk(clk), .reset(reset), .instr(instr), .imm(imm),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .raddr0(raddr0), .raddr1(raddr1), .rdata0(rdata0), .rdata1(rdata1),
        .waddr(waddr), .wdata(wdata), .wren(wren), .busy(busy),
        .done(done), .carry(carry), .zero(zero)
    );

    assign rdata0 = rf[raddr0];
    assign rdata1 = rf[raddr1];

    always @(posedge clk) begin
        if (rf_clear) begin
            for (int i = 0; i < 4; i++) rf[i] <= 8'h00;
        end else if (wren) begin
            rf[waddr] <= wdata;
        end
    end

    always @(posedge clk) begin
        if (wren) wren_cnt <= wren_cnt + 1;
    end

    task automatic check_value(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic idle_cycles(input int n);
        instr_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check_value("idle_ready", instr_ready, 1);
            check_value("idle_wren", wren, 0);
        end
    endtask

    // rst_at: 0 = none, 1 = reset during READ, 2 = reset during WRITE
    task automatic run_instr(input int op, input int rd, input int rs, input int rt,
                             input int im, input bit hold, input int rst_at);
        int waited, a, b, res, c;
        instr       = {op[1:0], rd[1:0], rs[1:0], rt[1:0]};
        imm         = im[7:0];
        instr_valid = 1'b1;
        waited      = 0;
        while (!instr_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!instr_ready) begin
            check_value("accept_timeout", 0, 1);
            instr_valid = 1'b0;
            return;
        end
        a = m_rf[rs];
        b = m_rf[rt];
        case (op)
            0: begin res = a + b; c = (res > 255) ? 1 : 0; end
            1: begin res = a - b; c = (a < b) ? 1 : 0; end
            2: begin res = a; c = m_carry; end
            default: begin res = im; c = m_carry; end
        endcase
        res = res & 255;

        @(posedge clk); #1;
        if (hold && rst_at == 0) begin
            instr = 8'($urandom);
            imm   = 8'($urandom);
        end else begin
            instr_valid = 1'b0;
        end
        check_value("read_ready", instr_ready, 0);
        check_value("read_busy", busy, 1);
        check_value("read_wren", wren, 0);
        check_value("read_done", done, 0);
        check_value("read_raddr0", raddr0, rs);
        check_value("read_raddr1", raddr1, rt);
        if (rst_at == 1) reset = 1'b1;

        @(posedge clk); #1;
        if (rst_at == 1) begin
            reset   = 1'b0;
            m_carry = 0;
            m_zero  = 0;
            check_value("rstrd_wren", wren, 0);
            check_value("rstrd_done", done, 0);
            check_value("rstrd_ready", instr_ready, 1);
            check_value("rstrd_busy", busy, 0);
            @(posedge clk); #1;
            check_value("rstrd_wren2", wren, 0);
            check_value("rstrd_carry", carry, 0);
            check_value("rstrd_zero", zero, 0);
            check_value("rstrd_ready2", instr_ready, 1);
            return;
        end
        check_value("wb_wren", wren, 1);
        check_value("wb_done", done, 1);
        check_value("wb_waddr", waddr, rd);
        check_value("wb_wdata", wdata, res);
        check_value("wb_ready", instr_ready, 0);
        m_rf[rd] = res;
        exp_writes++;
        if (rst_at == 2) reset = 1'b1;

        @(posedge clk); #1;
        if (rst_at == 2) begin
            reset   = 1'b0;
            m_carry = 0;
            m_zero  = 0;
        end else begin
            m_carry = c;
            m_zero  = (res == 0) ? 1 : 0;
        end
        check_value("post_wren", wren, 0);
        check_value("post_done", done, 0);
        check_value("post_ready", instr_ready, 1);
        check_value("post_busy", busy, 0);
        check_value("post_carry", carry, m_carry);
        check_value("post_zero", zero, m_zero);
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        exp_writes  = 0;
        m_carry     = 0;
        m_zero      = 0;
        for (int i = 0; i < 4; i++) m_rf[i] = 0;
        reset       = 1'b1;
        rf_clear    = 1'b1;
        instr_valid = 1'b0;
        instr       = 8'h00;
        imm         = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset    = 1'b0;
        rf_clear = 1'b0;

        check_value("rst_ready", instr_ready, 1);
        check_value("rst_busy", busy, 0);
        check_value("rst_wren", wren, 0);
        check_value("rst_done", done, 0);
        check_value("rst_carry", carry, 0);
        check_value("rst_zero", zero, 0);
        check_value("rst_raddr0", raddr0, 0);
        check_value("rst_raddr1", raddr1, 0);
        check_value("rst_waddr", waddr, 0);
        check_value("rst_wdata", wdata, 0);

        // LDI r1/r2, ADD carry/no-carry, SUB borrow and zero
        run_instr(3, 1, 0, 0, 8'hAA, 1'b0, 0);
        run_instr(3, 2, 0, 0, 8'h55, 1'b0, 0);
        run_instr(0, 3, 1, 2, 0, 1'b0, 0);
        check_value("tp_r3", rf[3], 8'hFF);
        run_instr(0, 0, 3, 1, 0, 1'b0, 0);
        check_value("tp_add_carry", carry, 1);
        run_instr(1, 0, 2, 1, 0, 1'b0, 0);
        check_value("tp_sub_r0", rf[0], 8'hAB);
        run_instr(1, 0, 1, 1, 0, 1'b0, 0);
        check_value("tp_sub_zero", zero, 1);
        idle_cycles(2);

        // continuous valid with junk instructions while busy
        run_instr(2, 3, 1, 0, 0, 1'b1, 0);
        run_instr(2, 0, 2, 1, 0, 1'b1, 0);
        run_instr(2, 1, 3, 2, 0, 1'b1, 0);
        idle_cycles(1);

        run_instr(0, 2, 1, 3, 0, 1'b0, 1);
        run_instr(3, 2, 0, 0, 8'h00, 1'b0, 0);
        run_instr(0, 1, 2, 3, 0, 1'b0, 2);
        idle_cycles(1);

        for (int k = 0; k < 40; k++) begin
            run_instr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 255),
                      1'($urandom_range(0, 1)), 0);
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
        end
        idle_cycles(2);

        for (int i = 0; i < 4; i++) check_value("final_rf", rf[i], m_rf[i]);
        check_value("wren_count", wren_cnt, exp_writes);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
